// File: rtl/branch_predictor_if.sv
// Shared types and the branch-queue push interface used by branch_predictor.
package branch_predictor_pkg;
  typedef logic [63:0] xlen_t;
  typedef logic [7:0]  id_t;
  typedef logic [3:0]  bq_id_t;
  typedef enum logic [2:0] {JAL, JALR, BEQ, BNE, BLT, BGE, BLTU, BGEU} ctrl_set_t;
  typedef struct packed {
    logic  taken;
    xlen_t pcnext;
  } bp_t;
endpackage

interface bq_push_if;
  import branch_predictor_pkg::*;
  logic   valid;
  logic   ready;
  bp_t    bp;
  xlen_t  pc;
  id_t    id;
  bq_id_t bqid;
  modport master (output valid, bp, pc, id, input ready, bqid);
  modport slave  (input valid, bp, pc, id, output ready, bqid);
endinterface

// File: rtl/branch_predictor.sv
// Branch predictor: one-entry stage between decode and the branch queue, 2-bit BHT direction
// prediction, and a direct-mapped JALR target buffer when BP_BTB_EN is defined.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int NR_BHT_ENTRIES = 64,
  parameter int NR_BTB_ENTRIES = 16
) (
  input  logic      clk,
  input  logic      rstn,
  input  logic      dec_valid,
  output logic      dec_ready,
  input  xlen_t     dec_pc,
  input  id_t       dec_id,
  input  xlen_t     dec_imm,
  input  ctrl_set_t dec_op,
  bq_push_if.master bq_push_io,
  output logic      out_valid,
  output id_t       out_id,
  output bq_id_t    out_bqid,
  output logic      redirect_valid,
  output xlen_t     redirect_pc,
  input  logic      upd_valid,
  input  xlen_t     upd_pc,
  input  ctrl_set_t upd_op,
  input  logic      upd_taken,
  input  xlen_t     upd_target,
  input  logic      flush_i
);
  localparam int BHT_W = $clog2(NR_BHT_ENTRIES);

  logic  full_q, full_d;
  xlen_t pc_q, pc_d;
  id_t   id_q, id_d;
  bp_t   bp_q, bp_d;
  logic  push_fire, accept;
  bp_t   pred, btb_pred;
  xlen_t pc_taken, pc_seq;

  logic [1:0]       bht_q [NR_BHT_ENTRIES];
  logic [1:0]       bht_cur, bht_upd_d;
  logic [BHT_W-1:0] bht_rd_idx, bht_wr_idx;
  logic             upd_cond;

  assign pc_taken   = dec_pc + dec_imm;
  assign pc_seq     = dec_pc + 64'd4;
  assign bht_rd_idx = dec_pc[BHT_W+1:2];
  assign bht_wr_idx = upd_pc[BHT_W+1:2];
  assign upd_cond   = upd_valid && (upd_op != JAL) && (upd_op != JALR);

  always_comb begin
    pred.taken  = 1'b0;
    pred.pcnext = pc_seq;
    case (dec_op)
      JAL: begin
        pred.taken  = 1'b1;
        pred.pcnext = pc_taken;
      end
      JALR: begin
        pred.taken  = btb_pred.taken;
        pred.pcnext = {btb_pred.pcnext[63:1], 1'b0};
      end
      default: begin
        pred.taken  = bht_q[bht_rd_idx][1];
        pred.pcnext = pred.taken ? pc_taken : pc_seq;
      end
    endcase
  end

  // Lookup reads the registered array, so a same-cycle update is seen only next cycle.
  assign bht_cur = bht_q[bht_wr_idx];
  always_comb begin
    bht_upd_d = bht_cur;
    if (upd_taken) begin
      if (bht_cur != 2'b11) bht_upd_d = bht_cur + 2'd1;
    end else if (bht_cur != 2'b00) begin
      bht_upd_d = bht_cur - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NR_BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
    end else if (upd_cond) begin
      bht_q[bht_wr_idx] <= bht_upd_d;
    end
  end

`ifdef BP_BTB_EN
  localparam int BTB_W = $clog2(NR_BTB_ENTRIES);
  localparam int TAG_W = 64 - BTB_W - 2;

  logic             btb_vld_q [NR_BTB_ENTRIES];
  logic [TAG_W-1:0] btb_tag_q [NR_BTB_ENTRIES];
  xlen_t            btb_tgt_q [NR_BTB_ENTRIES];
  logic [BTB_W-1:0] btb_rd_idx, btb_wr_idx;
  logic             btb_wr;
  logic [1:0]       unused_upd_pc_lo;

  assign btb_rd_idx       = dec_pc[BTB_W+1:2];
  assign btb_wr_idx       = upd_pc[BTB_W+1:2];
  assign btb_wr           = upd_valid && (upd_op == JALR);
  assign unused_upd_pc_lo = upd_pc[1:0];

  always_comb begin
    btb_pred.taken  = 1'b0;
    btb_pred.pcnext = pc_seq;
    if (btb_vld_q[btb_rd_idx] && (btb_tag_q[btb_rd_idx] == dec_pc[63:BTB_W+2])) begin
      btb_pred.taken  = 1'b1;
      btb_pred.pcnext = btb_tgt_q[btb_rd_idx];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NR_BTB_ENTRIES; i++) btb_vld_q[i] <= 1'b0;
    end else if (btb_wr) begin
      btb_vld_q[btb_wr_idx] <= 1'b1;
    end
  end

  // Tag and target are qualified by the valid bit, so they need no reset.
  always_ff @(posedge clk) begin
    if (btb_wr) begin
      btb_tag_q[btb_wr_idx] <= upd_pc[63:BTB_W+2];
      btb_tgt_q[btb_wr_idx] <= upd_target;
    end
  end
`else
  localparam int unused_btb_entries = NR_BTB_ENTRIES;
  logic unused_upd;

  assign btb_pred.taken  = 1'b0;
  assign btb_pred.pcnext = pc_seq;
  assign unused_upd      = ^{upd_pc[63:BHT_W+2], upd_pc[1:0], upd_target};
`endif

  assign bq_push_io.valid = full_q && !flush_i;
  assign bq_push_io.bp    = bp_q;
  assign bq_push_io.pc    = pc_q;
  assign bq_push_io.id    = id_q;
  assign push_fire        = bq_push_io.valid && bq_push_io.ready;
  assign dec_ready        = (!full_q || push_fire) && !flush_i;
  assign accept           = dec_valid && dec_ready;

  assign out_valid      = push_fire;
  assign out_id         = id_q;
  assign out_bqid       = bq_push_io.bqid;
  assign redirect_valid = push_fire && bp_q.taken;
  assign redirect_pc    = bp_q.pcnext;

  always_comb begin
    full_d = full_q;
    pc_d   = pc_q;
    id_d   = id_q;
    bp_d   = bp_q;
    if (flush_i) begin
      full_d = 1'b0;
    end else if (accept) begin
      full_d = 1'b1;
      pc_d   = dec_pc;
      id_d   = dec_id;
      bp_d   = pred;
    end else if (push_fire) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      full_q <= 1'b0;
      pc_q   <= '0;
      id_q   <= '0;
      bp_q   <= '0;
    end else begin
      full_q <= full_d;
      pc_q   <= pc_d;
      id_q   <= id_d;
      bp_q   <= bp_d;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: expected pushes come from a small BHT/BTB model into a scoreboard
// queue and are compared when the DUT pushes to the branch queue.
module tb_branch_predictor;
  import branch_predictor_pkg::*;

  typedef struct packed {
    id_t   id;
    xlen_t pc;
    bp_t   bp;
  } exp_t;

  logic      clk, rstn;
  logic      dec_valid, dec_ready;
  xlen_t     dec_pc, dec_imm;
  id_t       dec_id;
  ctrl_set_t dec_op;
  logic      out_valid, redirect_valid;
  id_t       out_id;
  bq_id_t    out_bqid;
  xlen_t     redirect_pc;
  logic      upd_valid, upd_taken, flush_i;
  xlen_t     upd_pc, upd_target;
  ctrl_set_t upd_op;
  bq_id_t    bqid_drv;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  logic [1:0] m_bht [64];
`ifdef BP_BTB_EN
  logic  m_btb_v   [16];
  xlen_t m_btb_pc  [16];
  xlen_t m_btb_tgt [16];
`endif

  bq_push_if bq ();

  branch_predictor dut (
    .clk(clk), .rstn(rstn),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_pc(dec_pc), .dec_id(dec_id),
    .dec_imm(dec_imm), .dec_op(dec_op), .bq_push_io(bq),
    .out_valid(out_valid), .out_id(out_id), .out_bqid(out_bqid),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_op(upd_op), .upd_taken(upd_taken),
    .upd_target(upd_target), .flush_i(flush_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_bht[i] = 2'b01;
`ifdef BP_BTB_EN
    for (int i = 0; i < 16; i++) m_btb_v[i] = 1'b0;
`endif
    sb.delete();
  endtask

  function automatic exp_t model_predict(input ctrl_set_t op, input xlen_t pc, input xlen_t imm, input id_t id);
    exp_t e;
    e.id = id;
    e.pc = pc;
    e.bp.taken = 1'b0;
    e.bp.pcnext = pc + 64'd4;
    if (op == JAL) begin
      e.bp.taken = 1'b1;
      e.bp.pcnext = pc + imm;
    end else if (op == JALR) begin
`ifdef BP_BTB_EN
      if (m_btb_v[pc[5:2]] && m_btb_pc[pc[5:2]][63:6] == pc[63:6]) begin
        e.bp.taken = 1'b1;
        e.bp.pcnext = m_btb_tgt[pc[5:2]] & ~64'd1;
      end
`endif
    end else begin
      e.bp.taken = m_bht[pc[7:2]][1];
      if (e.bp.taken) e.bp.pcnext = pc + imm;
    end
    return e;
  endfunction

  task automatic model_upd(input ctrl_set_t op, input xlen_t pc, input logic tk, input xlen_t tgt);
    if (op == JALR) begin
`ifdef BP_BTB_EN
      m_btb_v[pc[5:2]] = 1'b1;
      m_btb_pc[pc[5:2]] = pc;
      m_btb_tgt[pc[5:2]] = tgt;
`endif
    end else if (op != JAL) begin
      if (tk) begin
        if (m_bht[pc[7:2]] != 2'b11) m_bht[pc[7:2]] = m_bht[pc[7:2]] + 2'd1;
      end else if (m_bht[pc[7:2]] != 2'b00) begin
        m_bht[pc[7:2]] = m_bht[pc[7:2]] - 2'd1;
      end
    end
  endtask

  task automatic idle();
    dec_valid = 1'b0;
    upd_valid = 1'b0;
    flush_i = 1'b0;
  endtask

  task automatic set_dec(input ctrl_set_t op, input xlen_t pc, input xlen_t imm, input id_t id);
    dec_valid = 1'b1; dec_op = op; dec_pc = pc; dec_imm = imm; dec_id = id;
  endtask

  task automatic set_upd(input ctrl_set_t op, input xlen_t pc, input logic tk, input xlen_t tgt);
    upd_valid = 1'b1; upd_op = op; upd_pc = pc; upd_taken = tk; upd_target = tgt;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    idle();
    dec_op = BEQ; dec_pc = '0; dec_imm = '0; dec_id = '0;
    upd_op = BEQ; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
    bqid_drv = '0; bq.bqid = bqid_drv; bq.ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (bq.valid !== 1'b0 || out_valid !== 1'b0 || redirect_valid !== 1'b0)
      $display("FAIL reset_outputs: valid=%b out_valid=%b redirect=%b want 0/0/0", bq.valid, out_valid, redirect_valid);
    if (bq.valid !== 1'b0 || out_valid !== 1'b0 || redirect_valid !== 1'b0) failures++;
    rstn = 1'b1;
    model_reset();
    @(negedge clk); #1;
    checks++;
    if (dec_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: dec_ready=%b want 1", dec_ready); end
  endtask

  task automatic test_jal();
    exp_t e;
    @(negedge clk); idle(); bq.ready = 1'b1; bqid_drv = 4'd5; bq.bqid = bqid_drv;
    set_dec(JAL, 64'h1000, 64'h40, 8'd1);
    #1; checks++;
    if (dec_ready !== 1'b1) begin failures++; $display("FAIL jal_accept: dec_ready=%b want 1", dec_ready); end
    sb.push_back(model_predict(JAL, 64'h1000, 64'h40, 8'd1));
    @(negedge clk); set_dec(JAL, 64'hFFFF_FFFF_FFFF_FFF0, 64'h20, 8'd2);
    #1; checks++;
    if (bq.valid !== 1'b1 || out_valid !== 1'b1 || dec_ready !== 1'b1 || sb.size() == 0) begin
      failures++; $display("FAIL jal_push: valid=%b out_valid=%b dec_ready=%b want 1/1/1", bq.valid, out_valid, dec_ready);
    end else begin
      e = sb.pop_front();
      checks++;
      if ({bq.id, bq.pc, bq.bp} !== e || bq.bp !== {1'b1, 64'h1040}) begin
        failures++; $display("FAIL jal_payload: got %h want %h", {bq.id, bq.pc, bq.bp}, e);
      end
      checks++;
      if (out_id !== 8'd1 || out_bqid !== 4'd5 || redirect_valid !== 1'b1 || redirect_pc !== 64'h1040) begin
        failures++; $display("FAIL jal_out: id=%h bqid=%h redir=%b pc=%h want 01/5/1/1040", out_id, out_bqid, redirect_valid, redirect_pc);
      end
    end
    sb.push_back(model_predict(JAL, 64'hFFFF_FFFF_FFFF_FFF0, 64'h20, 8'd2));
    @(negedge clk); idle(); #1; checks++;
    if (bq.valid !== 1'b1 || sb.size() == 0) begin
      failures++; $display("FAIL jal_wrap_push: valid=%b want 1", bq.valid);
    end else begin
      e = sb.pop_front();
      checks++;
      if ({bq.id, bq.pc, bq.bp} !== e || bq.bp.pcnext !== 64'h10) begin
        failures++; $display("FAIL jal_wrap: got %h want %h", {bq.id, bq.pc, bq.bp}, e);
      end
    end
    @(negedge clk); #1; checks++;
    if (bq.valid !== 1'b0) begin failures++; $display("FAIL jal_empty: valid=%b want 0", bq.valid); end
  endtask

  task automatic test_bht();
    exp_t e;
    @(negedge clk); idle(); set_dec(BEQ, 64'h2000, 64'h100, 8'd2);
    #1; checks++;
    if (dec_ready !== 1'b1) begin failures++; $display("FAIL bht_accept: dec_ready=%b want 1", dec_ready); end
    sb.push_back(model_predict(BEQ, 64'h2000, 64'h100, 8'd2));
    @(negedge clk); idle(); set_upd(BEQ, 64'h2000, 1'b1, '0);
    #1; checks++;
    if (bq.valid !== 1'b1 || sb.size() == 0) begin
      failures++; $display("FAIL bht_nt_push: valid=%b want 1", bq.valid);
    end else begin
      e = sb.pop_front();
      checks++;
      if ({bq.id, bq.pc, bq.bp} !== e || bq.bp !== {1'b0, 64'h2004} || redirect_valid !== 1'b0) begin
        failures++; $display("FAIL bht_nt_pred: got %h redir=%b want %h", {bq.id, bq.pc, bq.bp}, redirect_valid, e);
      end
    end
    model_upd(BEQ, 64'h2000, 1'b1, '0);
    @(negedge clk); set_upd(BEQ, 64'h2000, 1'b1, '0); #1;
    model_upd(BEQ, 64'h2000, 1'b1, '0);
    @(negedge clk); set_dec(BEQ, 64'h2000, 64'h100, 8'd3); set_upd(BEQ, 64'h2000, 1'b0, '0);
    #1; checks++;
    if (dec_ready !== 1'b1) begin failures++; $display("FAIL bht_same_accept: dec_ready=%b want 1", dec_ready); end
    sb.push_back(model_predict(BEQ, 64'h2000, 64'h100, 8'd3));
    model_upd(BEQ, 64'h2000, 1'b0, '0);
    @(negedge clk); idle(); #1; checks++;
    if (bq.valid !== 1'b1 || sb.size() == 0) begin
      failures++; $display("FAIL bht_t_push: valid=%b want 1", bq.valid);
    end else begin
      e = sb.pop_front();
      checks++;
      if ({bq.id, bq.pc, bq.bp} !== e || bq.bp !== {1'b1, 64'h2100} || redirect_valid !== 1'b1 || redirect_pc !== 64'h2100) begin
        failures++; $display("FAIL bht_t_pred: got %h redir=%b/%h want %h", {bq.id, bq.pc, bq.bp}, redirect_valid, redirect_pc, e);
      end
    end
  endtask

  task automatic test_saturate();
    exp_t e;
    logic [9:0] upd_tk  = 10'b11_0000_0111;
    logic [9:0] want_tk = 10'b10_0000_1111;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); idle(); set_upd(BNE, 64'h2010, upd_tk[i], '0); #1;
      model_upd(BNE, 64'h2010, upd_tk[i], '0);
      @(negedge clk); idle(); set_dec(BNE, 64'h2010, 64'h80, id_t'(50 + i)); #1;
      checks++;
      if (dec_ready !== 1'b1) begin failures++; $display("FAIL sat_accept: step %0d dec_ready=%b want 1", i, dec_ready); end
      sb.push_back(model_predict(BNE, 64'h2010, 64'h80, id_t'(50 + i)));
      @(negedge clk); idle(); #1; checks++;
      if (bq.valid !== 1'b1 || sb.size() == 0) begin
        failures++; $display("FAIL sat_push: step %0d valid=%b want 1", i, bq.valid);
      end else begin
        e = sb.pop_front();
        checks++;
        if ({bq.id, bq.pc, bq.bp} !== e || bq.bp.taken !== want_tk[i]) begin
          failures++; $display("FAIL sat_step: step %0d got %h taken=%b want %h taken=%b", i, {bq.id, bq.pc, bq.bp}, bq.bp.taken, e, want_tk[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    @(negedge clk); idle(); bq.ready = 1'b1; set_dec(BLT, 64'h4000, 64'hFFFF_FFFF_FFFF_FFF8, 8'd10); #1;
    checks++;
    if (dec_ready !== 1'b1) begin failures++; $display("FAIL bp_accept: dec_ready=%b want 1", dec_ready); end
    sb.push_back(model_predict(BLT, 64'h4000, 64'hFFFF_FFFF_FFFF_FFF8, 8'd10));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); bq.ready = 1'b0; set_dec(BGE, 64'h4100, 64'h10, 8'd11); #1;
      checks++;
      if (bq.valid !== 1'b1 || dec_ready !== 1'b0 || out_valid !== 1'b0 || redirect_valid !== 1'b0) begin
        failures++; $display("FAIL bp_stall: cycle %0d valid=%b dec_ready=%b out_valid=%b want 1/0/0", c, bq.valid, dec_ready, out_valid);
      end
      checks++;
      if (sb.size() == 0 || {bq.id, bq.pc, bq.bp} !== sb[0]) begin
        failures++; $display("FAIL bp_hold: cycle %0d payload %h changed", c, {bq.id, bq.pc, bq.bp});
      end
    end
    @(negedge clk); bq.ready = 1'b1; bqid_drv = 4'd9; bq.bqid = bqid_drv; #1;
    checks++;
    if (bq.valid !== 1'b1 || out_valid !== 1'b1 || dec_ready !== 1'b1 || sb.size() == 0) begin
      failures++; $display("FAIL bp_release: valid=%b out_valid=%b dec_ready=%b want 1/1/1", bq.valid, out_valid, dec_ready);
    end else begin
      e = sb.pop_front();
      checks++;
      if ({bq.id, bq.pc, bq.bp} !== e || out_bqid !== 4'd9 || out_id !== 8'd10) begin
        failures++; $display("FAIL bp_release_payload: got %h bqid=%h want %h bqid=9", {bq.id, bq.pc, bq.bp}, out_bqid, e);
      end
    end
    sb.push_back(model_predict(BGE, 64'h4100, 64'h10, 8'd11));
    @(negedge clk); idle(); #1; checks++;
    if (bq.valid !== 1'b1 || sb.size() == 0) begin
      failures++; $display("FAIL bp_next_push: valid=%b want 1", bq.valid);
    end else begin
      e = sb.pop_front();
      checks++;
      if ({bq.id, bq.pc, bq.bp} !== e) begin failures++; $display("FAIL bp_next_payload: got %h want %h", {bq.id, bq.pc, bq.bp}, e); end
    end
    @(negedge clk); #1; checks++;
    if (bq.valid !== 1'b0) begin failures++; $display("FAIL bp_single: valid=%b want 0", bq.valid); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    xlen_t pc, imm;
    ctrl_set_t op;
    logic [31:0] r;
    for (int i = 0; i <= 12; i++) begin
      @(negedge clk); idle(); bq.ready = 1'b1; bqid_drv = 4'($urandom); bq.bqid = bqid_drv;
      op = ctrl_set_t'(3'($urandom_range(0, 7)));
      pc = 64'h8000 + xlen_t'($urandom_range(0, 63)) * 64'd4;
      r = $urandom;
      imm = {{32{r[31]}}, r[31:2], 2'b00};
      if (i < 12) set_dec(op, pc, imm, id_t'(100 + i));
      if ($urandom_range(0, 1) == 1)
        set_upd(ctrl_set_t'(3'($urandom_range(0, 7))), 64'h8000 + xlen_t'($urandom_range(0, 63)) * 64'd4,
                1'($urandom_range(0, 1)), 64'h9000 + xlen_t'($urandom_range(0, 255)));
      #1;
      if (i > 0) begin
        checks++;
        if (bq.valid !== 1'b1 || out_valid !== 1'b1 || sb.size() == 0) begin
          failures++; $display("FAIL b2b_push: beat %0d valid=%b out_valid=%b want 1/1", i, bq.valid, out_valid);
        end else begin
          e = sb.pop_front();
          checks++;
          if ({bq.id, bq.pc, bq.bp} !== e || out_id !== e.id || out_bqid !== bqid_drv ||
              redirect_valid !== e.bp.taken || (e.bp.taken && redirect_pc !== e.bp.pcnext)) begin
            failures++; $display("FAIL b2b_payload: beat %0d got %h bqid=%h redir=%b want %h bqid=%h", i, {bq.id, bq.pc, bq.bp}, out_bqid, redirect_valid, e, bqid_drv);
          end
        end
      end
      if (i < 12) begin
        checks++;
        if (dec_ready !== 1'b1) begin failures++; $display("FAIL b2b_accept: beat %0d dec_ready=%b want 1", i, dec_ready); end
        sb.push_back(model_predict(op, pc, imm, id_t'(100 + i)));
      end
      if (upd_valid) model_upd(upd_op, upd_pc, upd_taken, upd_target);
    end
  endtask

  task automatic test_flush();
    exp_t e;
    @(negedge clk); idle(); bq.ready = 1'b1; set_dec(BEQ, 64'h2000, 64'h100, 8'd20); #1;
    checks++;
    if (dec_ready !== 1'b1) begin failures++; $display("FAIL flush_accept: dec_ready=%b want 1", dec_ready); end
    sb.push_back(model_predict(BEQ, 64'h2000, 64'h100, 8'd20));
    @(negedge clk); set_dec(BNE, 64'h2010, 64'h100, 8'd21); flush_i = 1'b1; #1;
    checks++;
    if (bq.valid !== 1'b0 || out_valid !== 1'b0 || redirect_valid !== 1'b0 || dec_ready !== 1'b0) begin
      failures++; $display("FAIL flush_suppress: valid=%b out_valid=%b redir=%b dec_ready=%b want 0/0/0/0", bq.valid, out_valid, redirect_valid, dec_ready);
    end
    if (sb.size() > 0) e = sb.pop_front();
    @(negedge clk); idle(); #1; checks++;
    if (bq.valid !== 1'b0) begin failures++; $display("FAIL flush_empty: valid=%b want 0", bq.valid); end
  endtask

  task automatic test_jalr();
    exp_t  e;
    xlen_t pcs  [3];
    bp_t   want [3];
    pcs[0] = 64'h3000; pcs[1] = 64'h3040; pcs[2] = 64'h3008;
`ifdef BP_BTB_EN
    want[0] = {1'b1, 64'h5000}; want[1] = {1'b0, 64'h3044}; want[2] = {1'b1, 64'h6000};
`else
    want[0] = {1'b0, 64'h3004}; want[1] = {1'b0, 64'h3044}; want[2] = {1'b0, 64'h300C};
`endif
    @(negedge clk); idle(); bq.ready = 1'b1; set_upd(JALR, 64'h3000, 1'b1, 64'h5000); #1;
    model_upd(JALR, 64'h3000, 1'b1, 64'h5000);
    @(negedge clk); set_upd(JALR, 64'h3008, 1'b1, 64'h6001); #1;
    model_upd(JALR, 64'h3008, 1'b1, 64'h6001);
    for (int i = 0; i <= 3; i++) begin
      @(negedge clk); idle();
      if (i < 3) set_dec(JALR, pcs[i], '0, id_t'(30 + i));
      #1;
      if (i > 0) begin
        checks++;
        if (bq.valid !== 1'b1 || sb.size() == 0) begin
          failures++; $display("FAIL jalr_push: lookup %0d valid=%b want 1", i - 1, bq.valid);
        end else begin
          e = sb.pop_front();
          checks++;
          if ({bq.id, bq.pc, bq.bp} !== e || bq.bp !== want[i-1]) begin
            failures++; $display("FAIL jalr_pred: lookup %0d got %h want %h", i - 1, bq.bp, want[i-1]);
          end
        end
      end
      if (i < 3) sb.push_back(model_predict(JALR, pcs[i], '0, id_t'(30 + i)));
    end
  endtask

  task automatic test_reset_mid_push();
    exp_t e;
    @(negedge clk); idle(); bq.ready = 1'b0; set_dec(BEQ, 64'h2000, 64'h100, 8'd40); #1;
    sb.push_back(model_predict(BEQ, 64'h2000, 64'h100, 8'd40));
    @(negedge clk); idle(); #1;
    checks++;
    if (bq.valid !== 1'b1) begin failures++; $display("FAIL rst_pending: valid=%b want 1", bq.valid); end
    #2 rstn = 1'b0;
    #1; checks++;
    if (bq.valid !== 1'b0 || out_valid !== 1'b0 || redirect_valid !== 1'b0) begin
      failures++; $display("FAIL rst_async: valid=%b out_valid=%b redir=%b want 0/0/0", bq.valid, out_valid, redirect_valid);
    end
    model_reset();
    @(negedge clk); rstn = 1'b1; bq.ready = 1'b1; #1;
    checks++;
    if (bq.valid !== 1'b0 || dec_ready !== 1'b1) begin
      failures++; $display("FAIL rst_release: valid=%b dec_ready=%b want 0/1", bq.valid, dec_ready);
    end
    @(negedge clk); set_dec(BEQ, 64'h2000, 64'h100, 8'd41); #1;
    sb.push_back(model_predict(BEQ, 64'h2000, 64'h100, 8'd41));
    @(negedge clk); idle(); #1; checks++;
    if (bq.valid !== 1'b1 || sb.size() == 0) begin
      failures++; $display("FAIL rst_post_push: valid=%b want 1", bq.valid);
    end else begin
      e = sb.pop_front();
      checks++;
      if ({bq.id, bq.pc, bq.bp} !== e || bq.bp !== {1'b0, 64'h2004} || bq.id !== 8'd41) begin
        failures++; $display("FAIL rst_bht_cleared: got %h want %h", {bq.id, bq.pc, bq.bp}, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_jal();
    test_bht();
    test_saturate();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_jalr();
    test_reset_mid_push();
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL sb_drain: %0d expected pushes never seen", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter NR_BHT_ENTRIES, default 64, number of 2-bit direction counters (power of 2).
REQ-002 SHALL have parameter NR_BTB_ENTRIES, default 16, number of direct-mapped JALR target entries (power of 2).
REQ-003 SHALL have ports (one clock; reset asynchronous, active-low):
  clk  in  1  clock
  rstn  in  1  asynchronous active-low reset
  dec_valid  in  1  control-flow instruction offered by decode
  dec_ready  out  1  predictor can accept
  dec_pc  in  xlen_t  instruction PC
  dec_id  in  id_t  instruction sequence number
  dec_imm  in  xlen_t  sign-extended immediate
  dec_op  in  ctrl_set_t  JAL, JALR, BEQ, BNE, BLT, BGE, BLTU, BGEU
  bq_push_io  master  bq_push_if  valid, bp, pc, id out; ready, bqid in
  out_valid  out  1  predicted instruction released to dispatch
  out_id  out  id_t  sequence number of released instruction
  out_bqid  out  bq_id_t  BQ slot allocated, carried to fuinput.bqid
  redirect_valid  out  1  fetch redirect on predicted-taken
  redirect_pc  out  xlen_t  predicted next PC
  upd_valid  in  1  resolved branch retired
  upd_pc  in  xlen_t  retired branch PC
  upd_op  in  ctrl_set_t  retired branch op
  upd_taken  in  1  actual outcome
  upd_target  in  xlen_t  actual target
  flush_i  in  1  pipeline flush

Function
REQ-004 SHALL contain one stage register (empty/full) holding pc, id, bp.
REQ-005 SHALL accept on dec_valid && dec_ready; dec_ready = !full || push_fire; accepted entry visible on bq_push_io in the next cycle.
REQ-006 SHALL compute prediction combinationally at acceptance: BHT index = dec_pc[log2(NR_BHT_ENTRIES)+1:2]; taken = counter[1].
REQ-007 SHALL predict JAL: taken=1, pcnext=dec_pc+dec_imm; conditional: pcnext = taken ? dec_pc+dec_imm : dec_pc+4; JALR per REQ-018.
REQ-008 SHALL drive bq_push_io.valid = full && !flush_i, with bp/pc/id from the stage register; push_fire = valid && ready.
REQ-009 SHALL hold bq_push_io payload stable while valid && !ready.
REQ-010 SHALL, in the push_fire cycle, assert out_valid with out_id = stage id and out_bqid = bq_push_io.bqid, and assert redirect_valid with redirect_pc = bp.pcnext if bp.taken.
REQ-011 SHALL on push_fire without acceptance go empty; with acceptance stay full with new entry (back-to-back, 1 push per cycle).
REQ-012 SHALL on upd_valid for a conditional op update its BHT counter: taken saturating increment to 11, else saturating decrement to 00; JAL/JALR leave BHT unchanged.
REQ-013 SHALL give lookup the pre-update counter value when lookup and update hit the same index in the same cycle.
REQ-014 SHALL on flush_i clear the stage register, suppress bq_push_io.valid, out_valid, redirect_valid and deassert dec_ready in that cycle.
REQ-015 SHALL compute all PC arithmetic modulo 2^64, pcnext bit 0 forced to 0 for JALR.

Reset
REQ-016 SHALL on rstn low asynchronously: stage empty, all BHT counters 01 (weakly not-taken), all BTB valid bits 0.
REQ-017 SHALL during/after reset drive bq_push_io.valid=0, out_valid=0, redirect_valid=0, dec_ready=1 (after release); reset mid-push discards the pending entry.

Configuration
REQ-018 SHALL with BP_BTB_EN defined include the BTB: JALR lookup index dec_pc[log2(NR_BTB_ENTRIES)+1:2], tag = remaining PC bits; hit => taken=1, pcnext=stored target; miss => taken=0, pcnext=dec_pc+4; upd_valid with upd_op==JALR writes tag, target, valid.
REQ-019 SHALL without BP_BTB_EN contain no BTB storage and predict every JALR taken=0, pcnext=dec_pc+4.

Verification
REQ-020 Reset, JAL pc=0x1000 imm=0x40 -> push next cycle bp={1,0x1040}, redirect_pc=0x1040, out_bqid=bqid.
REQ-021 BEQ pc=0x2000 after reset -> taken=0, pcnext=0x2004; two upd taken=1 at 0x2000 -> next BEQ at 0x2000 predicts taken, pcnext=0x2000+imm.
REQ-022 bq ready=0 for 3 cycles with entry held -> valid high, payload unchanged, dec_ready=0; ready=1 -> single push, dec_ready=1.
REQ-023 Flush with stage full and ready=1 -> no push, no out_valid, stage empty next cycle.
REQ-024 BP_BTB_EN: upd JALR pc=0x3000 target=0x5000, then JALR 0x3000 -> bp={1,0x5000}; without macro -> bp={0,0x3004}.
REQ-025 Four counter decrements from 11 -> saturates at 00, fifth decrement stays 00.
